// File: rtl/seq_multiplier_n.sv
// ============================================================================
//  Module   : seq_multiplier_n
//  Purpose  : Shift-add sequential multiplier, one multiplier bit per cycle,
//             unsigned or two's-complement, full 2*WIDTH-bit product.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_multiplier_n #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   is_signed,
    input  logic [WIDTH-1:0]       multiplicand,
    input  logic [WIDTH-1:0]       multiplier,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product
);

    localparam int              CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_load;

    logic [WIDTH:0]         r_acc;
    logic [WIDTH-1:0]       r_qr;
    logic [WIDTH-1:0]       r_mr;
    logic                   r_sgn;
    logic [CW-1:0]          r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_last;
    logic                   w_sub;
    logic                   w_fill;
    logic [WIDTH:0]         w_ext;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_acc_nxt;
    logic [WIDTH-1:0]       w_qr_nxt;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    assign w_last = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_CALC);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CALC;
                    w_load      = 1'b1;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_CALC;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath step
    // ------------------------------------------------------------------
    // The multiplier MSB carries negative weight in signed mode, so the
    // final partial product is subtracted rather than added.
    assign w_ext  = r_sgn ? {r_mr[WIDTH-1], r_mr} : {1'b0, r_mr};
    assign w_sub  = r_sgn & w_last;

    always_comb begin
        w_sum = r_acc;
        if (r_qr[0]) begin
            if (w_sub) begin
                w_sum = r_acc - w_ext;
            end else begin
                w_sum = r_acc + w_ext;
            end
        end
    end

    assign w_fill    = r_sgn & w_sum[WIDTH];
    assign w_acc_nxt = {w_fill, w_sum[WIDTH:1]};
    assign w_qr_nxt  = {w_sum[0], r_qr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_qr      <= '0;
            r_mr      <= '0;
            r_sgn     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_acc <= '0;
            r_qr  <= multiplier;
            r_mr  <= multiplicand;
            r_sgn <= is_signed;
            r_cnt <= '0;
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_nxt;
            r_qr  <= w_qr_nxt;
            r_cnt <= r_cnt + C_ONE;
            if (w_last) begin
                r_product <= {w_acc_nxt[WIDTH-1:0], w_qr_nxt};
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier_n.sv
// ============================================================================
//  Module   : tb_seq_multiplier_n
//  Purpose  : Directed self-checking bench for seq_multiplier_n (WIDTH 4 and 8).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_multiplier_n;

    logic        clk = 1'b0;
    logic        rst;

    logic        start4, sg4, busy4, done4;
    logic [3:0]  m4, q4;
    logic [7:0]  p4;

    logic        start8, sg8, busy8, done8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_multiplier_n #(.WIDTH(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .start        (start4),
        .is_signed    (sg4),
        .multiplicand (m4),
        .multiplier   (q4),
        .busy         (busy4),
        .done         (done4),
        .product      (p4)
    );

    seq_multiplier_n #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .start        (start8),
        .is_signed    (sg8),
        .multiplicand (m8),
        .multiplier   (q8),
        .busy         (busy8),
        .done         (done8),
        .product      (p8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op4(input string tag, input logic [3:0] m, input logic [3:0] q,
                       input logic s, input logic [7:0] exp);
        logic [7:0] prev;
        @(negedge clk);
        prev   = p4;
        start4 = 1'b1; m4 = m; q4 = q; sg4 = s;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, 32'({busy4, done4}), 32'(2'b10));
            chk({tag, "_hold"}, 32'(p4), 32'(prev));
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'({busy4, done4}), 32'(2'b01));
        chk(tag, 32'(p4), 32'(exp));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'({busy4, done4}), 32'(2'b00));
    endtask

    task automatic op8(input string tag, input logic [7:0] m, input logic [7:0] q,
                       input logic s, input logic [15:0] exp);
        @(negedge clk);
        start8 = 1'b1; m8 = m; q8 = q; sg8 = s;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, 32'({busy8, done8}), 32'(2'b10));
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'({busy8, done8}), 32'(2'b01));
        chk(tag, 32'(p8), 32'(exp));
    endtask

    initial begin
        int n;
        int nd;
        logic [7:0] pr;

        rst = 1'b1;
        start4 = 1'b0; sg4 = 1'b0; m4 = '0; q4 = '0;
        start8 = 1'b0; sg8 = 1'b0; m8 = '0; q8 = '0;
        repeat (3) @(negedge clk);
        chk("rst_flags4", 32'({busy4, done4}), 32'(2'b00));
        chk("rst_prod4",  32'(p4), 32'(0));
        chk("rst_flags8", 32'({busy8, done8}), 32'(2'b00));
        chk("rst_prod8",  32'(p8), 32'(0));

        // reset wins over start on the same edge
        start4 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start4 = 1'b0;
        chk("rst_prio", 32'({busy4, done4}), 32'(2'b00));
        @(negedge clk);
        chk("rst_prio_idle", 32'({busy4, done4}), 32'(2'b00));

        op4("u15x15", 4'hF, 4'hF, 1'b0, 8'hE1);
        op4("u0x9",   4'h0, 4'h9, 1'b0, 8'h00);
        op4("s-8x-8", 4'h8, 4'h8, 1'b1, 8'h40);
        op4("s-3x5",  4'hD, 4'h5, 1'b1, 8'hF1);
        op4("s7x-1",  4'h7, 4'hF, 1'b1, 8'hF9);

        op8("s8_80x7F", 8'h80, 8'h7F, 1'b1, 16'hC080);
        op8("u8_80x7F", 8'h80, 8'h7F, 1'b0, 16'h3F80);

        // back-to-back with start held high
        @(negedge clk);
        start4 = 1'b1; m4 = 4'd3; q4 = 4'd5; sg4 = 1'b0;
        @(negedge clk);
        m4 = 4'd2; q4 = 4'd6;
        repeat (4) @(negedge clk);
        chk("b2b_done1", 32'({busy4, done4}), 32'(2'b01));
        chk("b2b_p1",    32'(p4), 32'(8'h0F));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start4 = 1'b0;
        end while (!done4 && n < 20);
        chk("b2b_gap", 32'(n), 32'(5));
        chk("b2b_p2",  32'(p4), 32'(8'h0C));
        @(negedge clk);
        chk("b2b_end", 32'({busy4, done4}), 32'(2'b00));

        // interference while busy
        @(negedge clk);
        start4 = 1'b1; m4 = 4'd6; q4 = 4'd7; sg4 = 1'b0;
        nd = 0; pr = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 4) begin
                start4 = i[0];
                m4     = 4'(i * 3 + 1);
                q4     = 4'(15 - i);
                sg4    = ~sg4;
            end else begin
                start4 = 1'b0;
            end
            if (done4) begin
                nd++;
                pr = p4;
            end
        end
        chk("intf_ndone", 32'(nd), 32'(1));
        chk("intf_prod",  32'(pr), 32'(8'h2A));
        chk("intf_hold",  32'(p4), 32'(8'h2A));

        // reset in the middle of a calculation
        @(negedge clk);
        start4 = 1'b1; m4 = 4'hF; q4 = 4'hF; sg4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_flags", 32'({busy4, done4}), 32'(2'b00));
        chk("midrst_prod",  32'(p4), 32'(0));
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) nd++;
        end
        chk("midrst_nodone", 32'(nd), 32'(0));
        op4("post_rst_4x4", 4'h4, 4'h4, 1'b0, 8'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_multiplier_n.md
# seq_multiplier_n

Parametrised shift-add sequential multiplier with an integrated controller, replacing the separate fixed 4-bit datapath/controller pair. It takes two WIDTH-bit operands, either unsigned or two's-complement, and processes one multiplier bit per cycle. It returns a full 2·WIDTH-bit product through a start/busy/done handshake. It sits between the operand registers and any consumer that needs multi-cycle multiply at minimal area.

## Interface
- WIDTH, default 4: operand width in bits; legal values are 2 to 32.
- clk  in  1: clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: request a multiply. Accepted only in IDLE or DONE.
- is_signed  in  1: 1 selects two's-complement operands, 0 selects unsigned. Sampled with start.
- multiplicand  in  WIDTH: operand M, sampled on the accepting edge.
- multiplier  in  WIDTH: operand Q, sampled on the accepting edge.
- busy  out  1: high while in CALC.
- done  out  1: one-cycle pulse in DONE.
- product  out  2·WIDTH: result register. Holds its value until the next result is written.

## Operation
- States and transitions:
  - IDLE: start=1 goes to CALC; otherwise stay in IDLE.
  - CALC: stays WIDTH cycles, then goes to DONE.
  - DONE: start=1 goes to CALC (back-to-back); otherwise goes to IDLE.
- Internal registers:
  - A: accumulator, WIDTH+1 bits.
  - Qr: multiplier shift register, WIDTH bits.
  - Mr: multiplicand, WIDTH bits.
  - sgn: latched mode.
  - cnt: step counter, ceil(log2(WIDTH+1)) bits.
- On accept: Mr←multiplicand, Qr←multiplier, sgn←is_signed, A←0, cnt←0.
- Each CALC cycle:
  - ext(Mr) is Mr sign-extended to WIDTH+1 bits if sgn, otherwise zero-extended.
  - If Qr[0]=1: S = A + ext(Mr). On the last step (cnt=WIDTH−1) with sgn=1, use S = A − ext(Mr) instead (MSB weight is negative).
  - If Qr[0]=0: S = A.
  - {A,Qr} ← {S,Qr} shifted right by 1. The fill bit is S[WIDTH] if sgn, otherwise 0.
  - cnt ← cnt+1.
  - S is computed modulo 2^(WIDTH+1). The unsigned sum cannot overflow WIDTH+1 bits.
- On the final CALC edge, product ← {A[WIDTH−1:0], Qr} taken from the post-shift values. This is the exact 2·WIDTH-bit result: unsigned M·Q, or the two's-complement M·Q.
- Operand and is_signed changes while busy=1 are ignored.
- start while in CALC is ignored; it is not queued.
- Reset behaviour:
  - rst=1 forces state IDLE, busy=0, done=0, product=0, and A, Qr, Mr, cnt, sgn all to 0.
  - Reset mid-CALC aborts the operation; no done pulse and no product update.
  - rst has priority over start on the same edge.

## Timing
- start is sampled high at edge k (state IDLE or DONE).
- busy=1 from after edge k through edge k+WIDTH.
- product is updated at edge k+WIDTH.
- done=1 in the cycle after edge k+WIDTH.
- Latency from start to done is WIDTH+1 edges (counting edge k as 0, done is visible after edge k+WIDTH).
- Throughput with start held high in DONE: one product every WIDTH+1 cycles.
- A start accepted in DONE reloads the operands on that same edge. done drops and busy rises after it.
- product keeps its old value during CALC until the final step.
- busy and done are never high together.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=4, unsigned:
  - 15×15, start at edge 0: busy for 4 cycles; product=0xE1; done pulse after edge 4.
  - 0×9 gives product=0x00.
- WIDTH=4, signed:
  - −8×−8 (0x8,0x8) gives 0x40.
  - −3×5 (0xD,0x5) gives 0xF1.
  - 7×−1 (0x7,0xF) gives 0xF9.
- WIDTH=8, signed −128×127 (0x80,0x7F) gives 0xC080. The same operands with is_signed=0 give 0x3F80.
- Back-to-back, WIDTH=4: 3×5 followed by 2×6, with start held high.
  - Products are 0x0F then 0x0C.
  - The second done comes exactly 5 cycles after the first.
- Interference, WIDTH=4, operands 6×7 (expected 0x2A):
  - Toggle start, is_signed and the operands during busy.
  - Result must still be 0x2A with a single done pulse.
- Reset, WIDTH=4:
  - Assert rst at CALC step 2: next cycle busy=0, done=0, product=0.
  - No done pulse may follow the reset.
  - A following 4×4 must give 0x10.
